arduino_to_fpga_spi: RTL and testbench

SPI slave receiver that deserializes one quaternion frame of four 32-bit words from the Arduino on MOSI, clocked directly by SPI `sclk`. It is the inbound counterpart of the FPGA-to-Arduino MISO path and uses the same framing: a dead gap before each word, then 32 bits LSB first. Completed frames are presented on `q0..q3` with a one-cycle `data_valid` strobe to the quaternion datapath.

---
 rtl/spi_quat_pkg.sv | 29 ++
 rtl/spi_word_deser.sv | 28 ++
 rtl/arduino_to_fpga_spi.sv | 138 +++++++++++++
 tb/tb_arduino_to_fpga_spi.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/spi_quat_pkg.sv
// Shared definitions for the quaternion SPI links (MOSI receiver and MISO transmitter).
package spi_quat_pkg;

  localparam int unsigned WORD_W      = 32;
  localparam int unsigned NUM_WORDS   = 4;
  localparam int unsigned BIT_CNT_W   = $clog2(WORD_W);
  localparam int unsigned IDX_W       = $clog2(NUM_WORDS);
  localparam int unsigned GAP_DEFAULT = 2;

  typedef enum logic {
    ST_GAP   = 1'b0,
    ST_SHIFT = 1'b1
  } spi_state_t;

  typedef struct packed {
    logic [WORD_W-1:0] q3;
    logic [WORD_W-1:0] q2;
    logic [WORD_W-1:0] q1;
    logic [WORD_W-1:0] q0;
  } quat_frame_t;

  // Posedges of sclk (with cs low) needed for one complete frame.
  function automatic int unsigned frame_edges(input int unsigned gap_cycles);
    return NUM_WORDS * (gap_cycles + WORD_W);
  endfunction

  localparam int unsigned FRAME_EDGES_DEFAULT = frame_edges(GAP_DEFAULT);

endpackage

// File: rtl/spi_word_deser.sv
// LSB-first serial-to-parallel shifter for one word, with bit counter and completion flag.
module spi_word_deser
  import spi_quat_pkg::*;
(
  input  logic                 sclk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 load_en,
  input  logic                 mosi,
  output logic [WORD_W-1:0]    word,
  output logic [BIT_CNT_W-1:0] bit_cnt,
  output logic                 word_done
);

  // High on the edge that samples the last bit of the word.
  assign word_done = load_en && (bit_cnt == BIT_CNT_W'(WORD_W - 1));

  always_ff @(posedge sclk) begin
    if (rst || clear) begin
      word    <= '0;
      bit_cnt <= '0;
    end else if (load_en) begin
      word    <= {mosi, word[WORD_W-1:1]};
      bit_cnt <= bit_cnt + BIT_CNT_W'(1);
    end
  end

endmodule

// File: rtl/arduino_to_fpga_spi.sv
// SPI slave receiver: deserializes a four-word quaternion frame from MOSI and
// presents it atomically on q0..q3 with a one-cycle data_valid strobe.
module arduino_to_fpga_spi
  import spi_quat_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned WORD_W     = 32
) (
  input  logic              sclk,
  input  logic              rst,
  input  logic              cs,
  input  logic              mosi,
  output logic [WORD_W-1:0] q0,
  output logic [WORD_W-1:0] q1,
  output logic [WORD_W-1:0] q2,
  output logic [WORD_W-1:0] q3,
  output logic              data_valid,
  output logic              frame_error
);

  localparam int unsigned GAP_W    = 2;
  localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYCLES == 0) ? '0 : GAP_W'(GAP_CYCLES - 1);

  spi_state_t          state, state_next;
  logic [GAP_W-1:0]    gap_cnt, gap_cnt_next;
  logic [IDX_W-1:0]    word_idx, word_idx_next;
  logic [WORD_W-1:0]   stage0, stage1, stage2;
  quat_frame_t         frame_q;

  logic                shifting_c;
  logic                load_en_c;
  logic                mid_frame_c;
  logic                frame_done_c;
  logic [WORD_W-1:0]   shreg;
  logic [WORD_W-1:0]   word_full_c;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic                word_done;

  // With no gap the FSM never leaves GAP and every edge is a data edge.
  assign shifting_c   = (state == ST_SHIFT) || (GAP_CYCLES == 0);
  assign load_en_c    = shifting_c && !cs;
  assign mid_frame_c  = (state == ST_SHIFT) || (gap_cnt != '0) || (bit_cnt != '0) || (word_idx != '0);
  assign frame_done_c = word_done && (word_idx == IDX_W'(NUM_WORDS - 1));
  assign word_full_c  = {mosi, shreg[WORD_W-1:1]};

  spi_word_deser u_deser (
    .sclk      (sclk),
    .rst       (rst),
    .clear     (cs),
    .load_en   (load_en_c),
    .mosi      (mosi),
    .word      (shreg),
    .bit_cnt   (bit_cnt),
    .word_done (word_done)
  );

  always_ff @(posedge sclk) begin
    if (rst) begin
      state    <= ST_GAP;
      gap_cnt  <= '0;
      word_idx <= '0;
    end else begin
      state    <= state_next;
      gap_cnt  <= gap_cnt_next;
      word_idx <= word_idx_next;
    end
  end

  always_comb begin
    state_next    = state;
    gap_cnt_next  = gap_cnt;
    word_idx_next = word_idx;
    if (cs) begin
      state_next    = ST_GAP;
      gap_cnt_next  = '0;
      word_idx_next = '0;
    end else begin
      unique case (state)
        ST_GAP: begin
          if (GAP_CYCLES == 0) begin
            if (word_done) word_idx_next = word_idx + IDX_W'(1);
          end else if (gap_cnt == GAP_LAST) begin
            state_next   = ST_SHIFT;
            gap_cnt_next = '0;
          end else begin
            gap_cnt_next = gap_cnt + GAP_W'(1);
          end
        end
        ST_SHIFT: begin
          if (word_done) begin
            word_idx_next = word_idx + IDX_W'(1);
            state_next    = ST_GAP;
          end
        end
        default: state_next = ST_GAP;
      endcase
    end
  end

  // Staging for words 0..2; word 3 is taken straight from the shifter.
  always_ff @(posedge sclk) begin
    if (rst) begin
      stage0 <= '0;
      stage1 <= '0;
      stage2 <= '0;
    end else if (word_done) begin
      case (word_idx)
        2'd0:    stage0 <= word_full_c;
        2'd1:    stage1 <= word_full_c;
        2'd2:    stage2 <= word_full_c;
        default: ;
      endcase
    end
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      frame_q     <= '0;
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (cs) begin
        if (mid_frame_c) frame_error <= 1'b1;
      end else if (frame_done_c) begin
        frame_q     <= '{q3: word_full_c, q2: stage2, q1: stage1, q0: stage0};
        data_valid  <= 1'b1;
        frame_error <= 1'b0;
      end
    end
  end

  assign q0 = frame_q.q0;
  assign q1 = frame_q.q1;
  assign q2 = frame_q.q2;
  assign q3 = frame_q.q3;

endmodule

// File: tb/tb_arduino_to_fpga_spi.sv
// Directed bench for arduino_to_fpga_spi: GAP_CYCLES = 2 and GAP_CYCLES = 0 instances.
module tb_arduino_to_fpga_spi;

  typedef logic [3:0][31:0] frame_t;

  typedef struct {
    int     which;
    frame_t f;
    int     exp_len;
  } vec_t;

  logic        sclk = 1'b0;
  logic        rst, cs, mosi, cs0, mosi0;
  logic [31:0] q0, q1, q2, q3, p0, p1, p2, p3;
  logic        dv, fe, dv0, fe0;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 sclk = ~sclk;

  arduino_to_fpga_spi #(.GAP_CYCLES(2), .WORD_W(32)) dut (
    .sclk(sclk), .rst(rst), .cs(cs), .mosi(mosi),
    .q0(q0), .q1(q1), .q2(q2), .q3(q3),
    .data_valid(dv), .frame_error(fe)
  );

  arduino_to_fpga_spi #(.GAP_CYCLES(0), .WORD_W(32)) dut0 (
    .sclk(sclk), .rst(rst), .cs(cs0), .mosi(mosi0),
    .q0(p0), .q1(p1), .q2(p2), .q3(p3),
    .data_valid(dv0), .frame_error(fe0)
  );

  function automatic frame_t get_q(input int which);
    return (which != 0) ? {p3, p2, p1, p0} : {q3, q2, q1, q0};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge sclk);
    #1;
  endtask

  // Drive the first n edges of a frame; records pulses, hold violations and error flag.
  task automatic run_frame(input int which, input frame_t f, input int n, input frame_t prev,
                           output int pulses, output int at, output int hold_bad,
                           output logic fe_pre, output logic fe_last);
    int gap, per, p, wd, off;
    logic b, d, e_flag;
    gap = (which != 0) ? 0 : 2;
    per = gap + 32;
    pulses = 0; at = -1; hold_bad = 0; fe_pre = 1'bx; fe_last = 1'bx;
    for (int e = 1; e <= n; e++) begin
      p   = e - 1;
      wd  = p / per;
      off = p % per;
      b   = (off < gap) ? 1'($urandom) : f[wd][off-gap];
      if (which != 0) begin cs0 = 1'b0; mosi0 = b; end
      else            begin cs  = 1'b0; mosi  = b; end
      step();
      d      = (which != 0) ? dv0 : dv;
      e_flag = (which != 0) ? fe0 : fe;
      if (d) begin
        pulses++;
        at = e;
      end else if (get_q(which) !== prev) begin
        hold_bad++;
      end
      if (e == n - 1) fe_pre = e_flag;
      fe_last = e_flag;
    end
  endtask

  vec_t   vecs[4];
  frame_t prev[2];
  frame_t fa, fb, fc, fd, fe_fr, ff, fg, fh, fz;
  int     pulses, at, hold_bad;
  logic   fe_pre, fe_last;

  initial begin
    fa    = {32'h12345678, 32'hBF000000, 32'h00000000, 32'h3F800000};
    fb    = {32'hFFFFFFFF, 32'h80000000, 32'h00000001, 32'hDEADBEEF};
    fc    = {32'h76543210, 32'hFEDCBA98, 32'h89ABCDEF, 32'h01234567};
    fd    = {32'hCAFEF00D, 32'h0F0F0F0F, 32'hF0F0F0F0, 32'h13579BDF};
    fe_fr = {32'h00000080, 32'h40490FDB, 32'hC0000000, 32'h7FFFFFFF};
    ff    = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    fg    = {32'hA5A5A5A5, 32'h5A5A5A5A, 32'hFFFF0000, 32'h0000FFFF};
    fh    = {32'h3F3504F3, 32'h00000000, 32'hBF3504F3, 32'h3F800000};
    fz    = '0;

    vecs[0] = '{which: 0, f: fa, exp_len: 136};
    vecs[1] = '{which: 0, f: fb, exp_len: 136};
    vecs[2] = '{which: 0, f: fc, exp_len: 136};
    vecs[3] = '{which: 1, f: {32'h55555555, 32'hAAAAAAAA, 32'h55555555, 32'hAAAAAAAA}, exp_len: 128};

    // Reset with cs low and random mosi
    rst = 1'b1; cs = 1'b0; cs0 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mosi = 1'($urandom); mosi0 = 1'($urandom);
      step();
    end
    chk("reset_q",      128'(get_q(0)), 128'(fz));
    chk("reset_dv",     128'(dv), 128'(0));
    chk("reset_fe",     128'(fe), 128'(0));
    chk("reset_q_gap0", 128'(get_q(1)), 128'(fz));
    chk("reset_dv_gap0", 128'(dv0), 128'(0));
    chk("reset_fe_gap0", 128'(fe0), 128'(0));
    rst = 1'b0; cs = 1'b1; cs0 = 1'b1;
    prev[0] = fz; prev[1] = fz;

    // Back-to-back frames from the table (GAP 0 entry runs while the other is idle)
    foreach (vecs[i]) begin
      run_frame(vecs[i].which, vecs[i].f, vecs[i].exp_len, prev[vecs[i].which],
                pulses, at, hold_bad, fe_pre, fe_last);
      chk($sformatf("vec%0d_pulses", i), 128'(pulses), 128'(1));
      chk($sformatf("vec%0d_pulse_edge", i), 128'(at), 128'(vecs[i].exp_len));
      chk($sformatf("vec%0d_q", i), 128'(get_q(vecs[i].which)), 128'(vecs[i].f));
      chk($sformatf("vec%0d_q_hold", i), 128'(hold_bad), 128'(0));
      chk($sformatf("vec%0d_fe", i), 128'(fe_last), 128'(0));
      prev[vecs[i].which] = vecs[i].f;
      if (i == 2) cs = 1'b1;
    end
    cs0 = 1'b1;
    step();
    chk("gap0_dv_clears", 128'(dv0), 128'(0));
    chk("dv_idle", 128'(dv), 128'(0));

    // Abort after 50 edges
    run_frame(0, fd, 50, prev[0], pulses, at, hold_bad, fe_pre, fe_last);
    chk("abort_no_pulse", 128'(pulses), 128'(0));
    cs = 1'b1;
    step();
    chk("abort_fe", 128'(fe), 128'(1));
    chk("abort_q_hold", 128'(get_q(0)), 128'(prev[0]));
    chk("abort_dv", 128'(dv), 128'(0));
    run_frame(0, fe_fr, 136, prev[0], pulses, at, hold_bad, fe_pre, fe_last);
    chk("after_abort_pulse_edge", 128'(at), 128'(136));
    chk("after_abort_q", 128'(get_q(0)), 128'(fe_fr));
    chk("after_abort_fe_held", 128'(fe_pre), 128'(1));
    chk("after_abort_fe_cleared", 128'(fe_last), 128'(0));
    prev[0] = fe_fr;

    // Idle edges between frames
    cs = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk("idle_fe", 128'(fe), 128'(0));
    chk("idle_q_hold", 128'(get_q(0)), 128'(prev[0]));
    run_frame(0, ff, 136, prev[0], pulses, at, hold_bad, fe_pre, fe_last);
    chk("idle_next_pulses", 128'(pulses), 128'(1));
    chk("idle_next_q", 128'(get_q(0)), 128'(ff));
    chk("idle_next_fe", 128'(fe_last), 128'(0));

    // Reset at bit 17 of word 2
    run_frame(0, fg, 2 * 34 + 2 + 17, ff, pulses, at, hold_bad, fe_pre, fe_last);
    chk("pre_rst_no_pulse", 128'(pulses), 128'(0));
    rst = 1'b1; cs = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mosi = 1'($urandom);
      step();
    end
    chk("midrst_q",  128'(get_q(0)), 128'(fz));
    chk("midrst_dv", 128'(dv), 128'(0));
    chk("midrst_fe", 128'(fe), 128'(0));
    rst = 1'b0;
    run_frame(0, fh, 136, fz, pulses, at, hold_bad, fe_pre, fe_last);
    chk("post_rst_pulse_edge", 128'(at), 128'(136));
    chk("post_rst_q", 128'(get_q(0)), 128'(fh));
    chk("post_rst_hold", 128'(hold_bad), 128'(0));

    cs = 1'b1;
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
